// File: rtl/ecpri_pkt_buf_ctrl.sv
// ecpri_pkt_buf_ctrl
// Receives an eCPRI packet byte stream and writes it into one of two fixed RAM
// slots used as a ping-pong FIFO. A packet is committed and presented to the consumer
// only if its length lies within [MIN_PKT_LEN, MAX_PKT_LEN]. Packets that are too
// short, too long, or that arrive while the target slot is still occupied are dropped
// and counted.
//
// Ports
//   clk, reset               sole clock (rising edge); asynchronous active-high reset
//   recv_pkt, inp_data_fifo  ingress byte strobe and data
//   pkt_end                  last byte of the packet (qualified by recv_pkt)
//   addr_0, wdata_0          registered RAM write address and data
//   cs_0, we_0, oe_0         RAM write-port controls (oe_0 is always 0)
//   pkt_valid                oldest committed packet is available
//   pkt_base, pkt_len        slot base address and byte count of that packet
//   pkt_done                 consumer pulse releasing the presented slot
//   pkt_cnt, drop_cnt        committed-packet counter (wraps) and dropped-packet
//                            counter (saturates)
// SLOT_STRIDE must be >= MAX_PKT_LEN so that the two slots never overlap.

module ecpri_pkt_buf_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned SLOT_STRIDE = 2048,
  parameter int unsigned MIN_PKT_LEN = 14,
  parameter int unsigned MAX_PKT_LEN = 1500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  recv_pkt,
  input  logic [DATA_WIDTH-1:0] inp_data_fifo,
  input  logic                  pkt_end,
  output logic [ADDR_WIDTH-1:0] addr_0,
  output logic [DATA_WIDTH-1:0] wdata_0,
  output logic                  cs_0,
  output logic                  we_0,
  output logic                  oe_0,
  output logic                  pkt_valid,
  output logic [ADDR_WIDTH-1:0] pkt_base,
  output logic [10:0]           pkt_len,
  input  logic                  pkt_done,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned LEN_W = 11;
  localparam logic [ADDR_WIDTH-1:0] SLOT1_BASE = ADDR_WIDTH'(SLOT_STRIDE);
  localparam logic [LEN_W-1:0]      MIN_LEN    = LEN_W'(MIN_PKT_LEN);
  localparam logic [LEN_W-1:0]      MAX_LEN    = LEN_W'(MAX_PKT_LEN);

  typedef enum logic [1:0] {StIdle, StWrite, StDrop, StCommit} state_e;

  state_e                r_state;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_full;
  logic [LEN_W-1:0]      r_len [2];
  logic [LEN_W-1:0]      r_cur_len;
  logic                  r_ram_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_pkt_valid;
  logic [ADDR_WIDTH-1:0] r_pkt_base;
  logic [LEN_W-1:0]      r_pkt_len;
  logic [15:0]           r_pkt_cnt;
  logic [15:0]           r_drop_cnt;

  state_e                w_state_nxt;
  logic [LEN_W-1:0]      w_cur_len_nxt;
  logic [LEN_W-1:0]      w_len_inc;
  logic                  w_start_slot;
  logic                  w_wr_en;
  logic                  w_wr_slot;
  logic [LEN_W-1:0]      w_wr_off;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic                  w_commit;
  logic                  w_drop;
  logic                  w_release;
  logic [1:0]            w_full_rel;
  logic [1:0]            w_full_nxt;
  logic                  w_rd_ptr_nxt;

  // Next-state and write-request decode
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_len_nxt = r_cur_len;
    w_len_inc     = r_cur_len + LEN_W'(1);
    w_wr_en       = 1'b0;
    w_wr_slot     = r_wr_ptr;
    w_wr_off      = r_cur_len;
    w_commit      = (r_state == StCommit);
    w_drop        = 1'b0;
    // In COMMIT the write pointer toggles at this edge, so a new packet targets the other slot
    w_start_slot  = r_wr_ptr ^ (r_state == StCommit);

    unique case (r_state)
      StIdle, StCommit: begin
        w_state_nxt = StIdle;
        if (recv_pkt) begin
          if (!r_full[w_start_slot]) begin
            w_wr_en       = 1'b1;
            w_wr_slot     = w_start_slot;
            w_wr_off      = '0;
            w_cur_len_nxt = LEN_W'(1);
            if (pkt_end) begin
              if (LEN_W'(1) >= MIN_LEN) begin
                w_state_nxt = StCommit;
              end else begin
                w_drop = 1'b1;
              end
            end else begin
              w_state_nxt = StWrite;
            end
          end else if (pkt_end) begin
            w_drop = 1'b1;
          end else begin
            w_state_nxt = StDrop;
          end
        end
      end
      StWrite: begin
        if (recv_pkt) begin
          if (r_cur_len >= MAX_LEN) begin
            // Byte would exceed the maximum length: discard it and the rest of the packet
            if (pkt_end) begin
              w_drop      = 1'b1;
              w_state_nxt = StIdle;
            end else begin
              w_state_nxt = StDrop;
            end
          end else begin
            w_wr_en       = 1'b1;
            w_cur_len_nxt = w_len_inc;
            if (pkt_end) begin
              if (w_len_inc >= MIN_LEN) begin
                w_state_nxt = StCommit;
              end else begin
                w_drop      = 1'b1;
                w_state_nxt = StIdle;
              end
            end
          end
        end
      end
      StDrop: begin
        if (recv_pkt && pkt_end) begin
          w_drop      = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    w_wr_addr = (w_wr_slot ? SLOT1_BASE : '0) + ADDR_WIDTH'(w_wr_off);
  end

  // Slot bookkeeping. pkt_valid is derived from the full flags before this edge's commit,
  // so it rises one cycle after COMMIT, once the last RAM write has completed.
  always_comb begin
    w_release    = pkt_done & r_pkt_valid;
    w_full_rel   = r_full;
    if (w_release) begin
      w_full_rel[r_rd_ptr] = 1'b0;
    end
    w_rd_ptr_nxt = r_rd_ptr ^ w_release;
    w_full_nxt   = w_full_rel;
    if (w_commit) begin
      w_full_nxt[r_wr_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_full      <= '0;
      r_len[0]    <= '0;
      r_len[1]    <= '0;
      r_cur_len   <= '0;
      r_ram_wr    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_pkt_valid <= 1'b0;
      r_pkt_base  <= '0;
      r_pkt_len   <= '0;
      r_pkt_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_len <= w_cur_len_nxt;
      r_full    <= w_full_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_ram_wr  <= w_wr_en;
      if (w_wr_en) begin
        r_addr  <= w_wr_addr;
        r_wdata <= inp_data_fifo;
      end
      if (w_commit) begin
        r_len[r_wr_ptr] <= r_cur_len;
        r_wr_ptr        <= ~r_wr_ptr;
        r_pkt_cnt       <= r_pkt_cnt + 16'd1;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      r_pkt_valid <= w_full_rel[w_rd_ptr_nxt];
      r_pkt_base  <= w_rd_ptr_nxt ? SLOT1_BASE : '0;
      r_pkt_len   <= r_len[w_rd_ptr_nxt];
    end
  end

  assign addr_0    = r_addr;
  assign wdata_0   = r_wdata;
  assign cs_0      = r_ram_wr;
  assign we_0      = r_ram_wr;
  assign oe_0      = 1'b0;
  assign pkt_valid = r_pkt_valid;
  assign pkt_base  = r_pkt_base;
  assign pkt_len   = r_pkt_len;
  assign pkt_cnt   = r_pkt_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule
